// File: rtl/inst_fetch.sv
// Fetch stage: drives the PC into instruction memory, captures the returned
// word into a one-entry valid/ready output register, and handles start,
// redirect, backpressure, halt detection and a delivered-instruction count.
//
// state | meaning
// IDLE  | waiting for start_i, no capture
// RUN   | fetching one word per cycle when the output register can take it
// HALT  | halt word seen, no capture until redirect_i or reset
module inst_fetch #(
    parameter int                 ADDR_W      = 8,
    parameter int                 INSTR_W     = 19,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [4:0]         HALT_OPCODE = 5'b11111,
    parameter int                 CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic [ADDR_W-1:0]  pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [ADDR_W-1:0]  out_pc_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   fetch_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc_nxt;
    logic                valid_nxt;
    logic [INSTR_W-1:0]  instr_nxt;
    logic [ADDR_W-1:0]   out_pc_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                accept;

    assign state_o = state;
    assign accept  = out_valid_o && out_ready_i;

    // State and datapath registers; pc_o comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc_o          <= RESET_PC;
            out_valid_o   <= 1'b0;
            out_instr_o   <= '0;
            out_pc_o      <= '0;
            fetch_count_o <= '0;
        end else begin
            state         <= state_nxt;
            pc_o          <= pc_nxt;
            out_valid_o   <= valid_nxt;
            out_instr_o   <= instr_nxt;
            out_pc_o      <= out_pc_nxt;
            fetch_count_o <= cnt_nxt;
        end
    end

    // Next-state, capture, redirect and counter logic.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_o;
        valid_nxt  = out_valid_o;
        instr_nxt  = out_instr_o;
        out_pc_nxt = out_pc_o;
        cnt_nxt    = fetch_count_o;

        // A handshake counts as delivered even when a redirect flushes it.
        if (accept && (fetch_count_o != {CNT_W{1'b1}}))
            cnt_nxt = fetch_count_o + 1'b1;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_RUN;
                    pc_nxt    = RESET_PC;
                end
            end
            S_RUN: begin
                if (redirect_i) begin
                    pc_nxt    = redirect_pc_i;
                    valid_nxt = 1'b0;
                end else if (!out_valid_o || out_ready_i) begin
                    instr_nxt  = instr_i;
                    out_pc_nxt = pc_o;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc_o + 1'b1;
                    if (instr_i[INSTR_W-1 -: 5] == HALT_OPCODE)
                        state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect_i) begin
                    state_nxt = S_RUN;
                    pc_nxt    = redirect_pc_i;
                    valid_nxt = 1'b0;
                end else if (accept) begin
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural instruction memory,
// scoreboard of expected {pc, instr} pairs popped on each handshake.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, redirect, ready;
    logic [7:0]  rpc;
    logic [7:0]  pc, out_pc;
    logic [18:0] instr, out_instr;
    logic        valid;
    logic [1:0]  state;
    logic [15:0] count;

    logic        w_start, w_ready;
    logic [7:0]  w_pc, w_out_pc;
    logic [18:0] w_instr, w_out_instr;
    logic        w_valid;
    logic [1:0]  w_state;
    logic [15:0] w_count;

    logic [18:0] mem [256];
    logic [26:0] sb [$];
    logic [26:0] exp_item;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign instr   = mem[pc];
    assign w_instr = mem[w_pc];

    inst_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .pc_o(pc), .instr_i(instr),
        .redirect_i(redirect), .redirect_pc_i(rpc), .out_valid_o(valid),
        .out_ready_i(ready), .out_instr_o(out_instr), .out_pc_o(out_pc),
        .state_o(state), .fetch_count_o(count)
    );

    inst_fetch #(.RESET_PC(8'd254)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start_i(w_start), .pc_o(w_pc), .instr_i(w_instr),
        .redirect_i(1'b0), .redirect_pc_i(8'd0), .out_valid_o(w_valid),
        .out_ready_i(w_ready), .out_instr_o(w_out_instr), .out_pc_o(w_out_pc),
        .state_o(w_state), .fetch_count_o(w_count)
    );

    task automatic do_reset();
        rst_n = 1'b0; start = 0; redirect = 0; ready = 0; rpc = 0;
        w_start = 0; w_ready = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            automatic logic [7:0] a = 8'(first + i);
            sb.push_back({a, mem[a]});
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state, pc, valid, out_instr, out_pc, count} !== {2'b00, 8'd0, 1'b0, 19'd0, 8'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state: state=%b pc=%0d valid=%b instr=%h opc=%0d cnt=%0d, want all zero",
                     state, pc, valid, out_instr, out_pc, count);
        end
        n_checks++;
        if (w_pc !== 8'd254) begin
            n_fail++; $display("FAIL reset_pc_param: got %0d want 254", w_pc);
        end
        @(negedge clk); rst_n = 1'b1;
        redirect = 1; rpc = 8'd50;
        @(negedge clk); redirect = 0;
        @(negedge clk);
        n_checks++;
        if (state !== 2'b00 || pc !== 8'd0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_redirect: state=%b pc=%0d valid=%b want 00/0/0", state, pc, valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        ready = 1; start = 1;
        push_range(0, 4);
        @(negedge clk); start = 0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (valid && ready) begin
                exp_item = sb.pop_front(); n_checks++;
                if ({out_pc, out_instr} !== exp_item) begin
                    n_fail++;
                    $display("FAIL stream_word: got pc=%0d instr=%h want pc=%0d instr=%h",
                             out_pc, out_instr, exp_item[26:19], exp_item[18:0]);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL stream_timeout: %0d left, want 0", sb.size()); end
        @(negedge clk); ready = 0;
        n_checks++;
        if (count !== 16'd4) begin n_fail++; $display("FAIL stream_count: got %0d want 4", count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        start = 1;
        push_range(0, 3);
        @(negedge clk); start = 0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (valid !== 1'b1 || out_instr !== 19'd1 || out_pc !== 8'd0 || pc !== 8'd1) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b instr=%h opc=%0d pc=%0d want 1/1/0/1", valid, out_instr, out_pc, pc);
            end
            @(negedge clk);
        end
        ready = 1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            if (c > 0) @(negedge clk);
            if (valid && ready) begin
                exp_item = sb.pop_front(); n_checks++;
                if ({out_pc, out_instr} !== exp_item) begin
                    n_fail++;
                    $display("FAIL stall_word: got pc=%0d instr=%h want pc=%0d instr=%h",
                             out_pc, out_instr, exp_item[26:19], exp_item[18:0]);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL stall_timeout: %0d left, want 0", sb.size()); end
        @(negedge clk); ready = 0;
        n_checks++;
        if (count !== 16'd3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", count); end
    endtask

    task automatic test_redirect();
        do_reset();
        ready = 1; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        redirect = 1; rpc = 8'd200;
        n_checks++;
        if (valid !== 1'b1 || out_pc !== 8'd0 || out_instr !== 19'd1) begin
            n_fail++; $display("FAIL redir_pre: valid=%b pc=%0d instr=%h want 1/0/1", valid, out_pc, out_instr);
        end
        @(negedge clk); redirect = 0;
        n_checks++;
        if (valid !== 1'b0 || count !== 16'd1 || pc !== 8'd200) begin
            n_fail++; $display("FAIL redir_flush: valid=%b cnt=%0d pc=%0d want 0/1/200", valid, count, pc);
        end
        push_range(200, 3);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (valid && ready) begin
                exp_item = sb.pop_front(); n_checks++;
                if ({out_pc, out_instr} !== exp_item) begin
                    n_fail++;
                    $display("FAIL redir_word: got pc=%0d instr=%h want pc=%0d instr=%h",
                             out_pc, out_instr, exp_item[26:19], exp_item[18:0]);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL redir_timeout: %0d left, want 0", sb.size()); end
        @(negedge clk); ready = 0;
        n_checks++;
        if (count !== 16'd4) begin n_fail++; $display("FAIL redir_count: got %0d want 4", count); end
    endtask

    task automatic test_halt();
        do_reset();
        mem[2] = {5'b11111, 14'd0};
        for (int pass = 0; pass < 2; pass++) begin
            ready = 1;
            if (pass == 0) begin
                start = 1;
                @(negedge clk); start = 0;
            end else begin
                redirect = 1; rpc = 8'd0;
                @(negedge clk); redirect = 0;
                n_checks++;
                if (state !== 2'b01 || valid !== 1'b0 || pc !== 8'd0) begin
                    n_fail++; $display("FAIL halt_exit: state=%b valid=%b pc=%0d want 01/0/0", state, valid, pc);
                end
            end
            push_range(0, 3);
            for (int c = 0; c < 20 && sb.size() > 0; c++) begin
                @(negedge clk);
                if (valid && ready) begin
                    exp_item = sb.pop_front(); n_checks++;
                    if ({out_pc, out_instr} !== exp_item) begin
                        n_fail++;
                        $display("FAIL halt_word: got pc=%0d instr=%h want pc=%0d instr=%h",
                                 out_pc, out_instr, exp_item[26:19], exp_item[18:0]);
                    end
                end
            end
            if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL halt_timeout: %0d left, want 0", sb.size()); end
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                start = (c == 1);
                n_checks++;
                if (state !== 2'b10 || pc !== 8'd3 || valid !== 1'b0) begin
                    n_fail++; $display("FAIL halt_hold: state=%b pc=%0d valid=%b want 10/3/0", state, pc, valid);
                end
            end
            start = 0;
        end
        n_checks++;
        if (count !== 16'd6) begin n_fail++; $display("FAIL halt_count: got %0d want 6", count); end
        mem[2] = 19'd3;
    endtask

    task automatic test_wrap();
        do_reset();
        w_ready = 1; w_start = 1;
        push_range(254, 4);
        @(negedge clk); w_start = 0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (w_valid && w_ready) begin
                exp_item = sb.pop_front(); n_checks++;
                if ({w_out_pc, w_out_instr} !== exp_item) begin
                    n_fail++;
                    $display("FAIL wrap_word: got pc=%0d instr=%h want pc=%0d instr=%h",
                             w_out_pc, w_out_instr, exp_item[26:19], exp_item[18:0]);
                end
            end
        end
        if (sb.size() != 0) begin n_checks++; n_fail++; $display("FAIL wrap_timeout: %0d left, want 0", sb.size()); end
        @(negedge clk); w_ready = 0;
        n_checks++;
        if (w_count !== 16'd4 || w_state !== 2'b01) begin
            n_fail++; $display("FAIL wrap_count: cnt=%0d state=%b want 4/01", w_count, w_state);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: valid=%b want 1", valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || pc !== 8'd0 || state !== 2'b00 || out_instr !== 19'd0) begin
            n_fail++;
            $display("FAIL areset_now: valid=%b pc=%0d state=%b instr=%h want 0/0/00/0", valid, pc, state, out_instr);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 19'(i + 1);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch-stage initiator for the 19-bit CPU and the requesting side of the instruction-memory interface. It drives the 8-bit PC into inst_mem and samples the combinationally returned 19-bit word. It then presents {pc, instruction} to decode through a one-entry valid/ready output register. It also handles start, branch/jump redirect, backpressure, halt-opcode detection and a delivered-instruction counter.

Parameters:
ADDR_W, 8, PC / instruction-memory address width; 256-word space.
INSTR_W, 19, instruction width.
RESET_PC, 0, PC loaded at reset and on start.
HALT_OPCODE, 5'b11111, value of instr[18:14] that halts fetch.
CNT_W, 16, width of the delivered-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous and active-low.
start_i  input  1  leaves IDLE and begins fetching at RESET_PC.
pc_o  output  ADDR_W  address to inst_mem; the current PC register.
instr_i  input  INSTR_W  inst_mem read data, valid in the same cycle as pc_o.
redirect_i  input  1  branch/jump taken; flushes the output and reloads the PC.
redirect_pc_i  input  ADDR_W  redirect target.
out_valid_o  output  1  output register holds an instruction.
out_ready_i  input  1  decode accepts the output this cycle.
out_instr_o  output  INSTR_W  fetched instruction.
out_pc_o  output  ADDR_W  address of out_instr_o.
state_o  output  2  00=IDLE, 01=RUN, 10=HALT.
fetch_count_o  output  CNT_W  number of instructions accepted by decode (valid and ready).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc_o=RESET_PC, out_valid_o=0, out_instr_o=0, out_pc_o=0, fetch_count_o=0. This applies mid-operation too: any pending output is discarded immediately.
- IDLE: no capture. A cycle with start_i=1 sets state=RUN and pc=RESET_PC. A redirect in IDLE is ignored.
- RUN, capture condition: cap = !redirect_i && (!out_valid_o || out_ready_i).
  - On cap: out_instr_o<=instr_i, out_pc_o<=pc_o, out_valid_o<=1, pc<=pc+1 (mod 2^ADDR_W, so 255 wraps to 0).
  - First valid output appears one edge after entering RUN.
  - Throughput is one instruction per cycle while out_ready_i is held high.
- Backpressure: while out_valid_o=1 and out_ready_i=0, out_instr_o, out_pc_o and pc hold stable.
- Accept without a new capture (e.g. HALT): a valid/ready handshake clears out_valid_o.
- Redirect (priority over capture and accept, in RUN or HALT): pc<=redirect_pc_i, out_valid_o<=0, state<=RUN.
  - The output being accepted in the same cycle still counts as delivered.
  - First instruction from the target is valid two edges after redirect_i is sampled.
- Halt: when the captured instr_i[18:14]==HALT_OPCODE, the halt word is delivered normally and state<=HALT at that same edge.
  - In HALT, no further capture; pc holds at halt address+1.
  - The halt word remains until accepted.
  - Exit from HALT only via redirect_i or reset. start_i is ignored outside IDLE.
- fetch_count_o increments on every cycle with out_valid_o && out_ready_i and saturates at all-ones.
- No combinational path from out_ready_i or redirect_i to pc_o: pc_o is purely registered.

Test Plan:
- Bench preloads inst_mem words 0..3 = 19'd1..19'd4. Pulse start_i with out_ready_i=1 → out_instr 1,2,3,4 on consecutive cycles, out_pc 0..3, fetch_count_o=4 after 4 accepts.
- Hold out_ready_i=0 for 5 cycles after the first valid → out_instr=1 and out_pc=0 stable, pc_o=1. Release ready → 2,3 follow back-to-back; no word is lost or duplicated.
- Redirect to 8'd200 while out_valid_o=1 and out_ready_i=1 → that word counted, out_valid_o=0 next cycle, then out_pc=200,201,...
- Set word 2 = {5'b11111,14'd0} → words 0,1,2 delivered, state_o=HALT, pc_o=3, no further valids. Redirect to 0 → state RUN, refetch from 0.
- Start with RESET_PC=254 (parameter override) → out_pc 254,255,0,1; wrap-around is correct.
- Assert rst_n=0 asynchronously mid-stream with out_valid_o=1 → out_valid_o=0 and pc_o=RESET_PC before the next clock edge; state=IDLE.
